// File: rtl/feedback_burst_scheduler_if.sv
// Request/grant bundle between requesters and the feedback burst scheduler.
// The master drives requests and burst lengths. The slave returns ownership and status.
interface feedback_burst_scheduler_if;
    logic [3:0]  req;
    logic [15:0] len_bus;
    logic [3:0]  grant;
    logic        window;
    logic [3:0]  done;
    logic        abort;
    logic        busy;

    modport master (
        output req, len_bus,
        input  grant, window, done, abort, busy
    );

    modport slave (
        input  req, len_bus,
        output grant, window, done, abort, busy
    );
endinterface

// File: rtl/feedback_burst_scheduler.sv
// Round-robin scheduler that grants one requester a window counting falling edges of ext_clk.
// Each burst is followed by a fixed idle gap before the next grant.
module feedback_burst_scheduler #(
    parameter int HOLDOFF_CYCLES = 2,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                         sysclk,
    input  logic                         reset,
    input  logic                         ext_clk,
    feedback_burst_scheduler_if.slave    bus
);

    typedef enum logic [1:0] {IDLE, COUNT, HOLDOFF} stateType;

    stateType               state;
    logic [SYNC_STAGES-1:0] syncReg;
    logic                   histReg;
    logic                   fallEvent;
    logic [1:0]             rrPtr;
    logic [1:0]             owner;
    logic [4:0]             edgeCnt;
    logic [4:0]             target;
    logic [3:0]             holdCnt;
    logic                   selFound;
    logic [1:0]             selIdx;
    logic [3:0]             selLen;
    logic                   lastEdge;

    // ext_clk is asynchronous, so it only enters the FSM after the synchronizer chain.
    always_ff @(posedge sysclk) begin
        if (!reset) begin
            syncReg <= '1;
            histReg <= 1'b1;
        end else begin
            syncReg <= {syncReg[SYNC_STAGES-2:0], ext_clk};
            histReg <= syncReg[SYNC_STAGES-1];
        end
    end

    assign fallEvent = histReg & ~syncReg[SYNC_STAGES-1];
    assign lastEdge  = fallEvent && (edgeCnt == target - 5'd1);

    // Search upward from rrPtr with wrap, so the last owner has the lowest priority next time.
    always_comb begin
        selFound = 1'b0;
        selIdx   = rrPtr;
        for (int i = 0; i < 4; i++) begin
            if (!selFound && bus.req[rrPtr + 2'(i)]) begin
                selFound = 1'b1;
                selIdx   = rrPtr + 2'(i);
            end
        end
    end

    assign selLen   = bus.len_bus[{selIdx, 2'b00} +: 4];
    assign bus.busy = (state != IDLE);

    always_ff @(posedge sysclk) begin
        if (!reset) begin
            state      <= IDLE;
            bus.grant  <= '0;
            bus.window <= 1'b0;
            bus.done   <= '0;
            bus.abort  <= 1'b0;
            rrPtr      <= '0;
            owner      <= '0;
            edgeCnt    <= '0;
            target     <= '0;
            holdCnt    <= '0;
        end else begin
            bus.done  <= '0;
            bus.abort <= 1'b0;
            case (state)
                IDLE: begin
                    if (selFound) begin
                        state      <= COUNT;
                        bus.grant  <= 4'b0001 << selIdx;
                        bus.window <= 1'b1;
                        target     <= {selLen == 4'd0, selLen};
                        edgeCnt    <= '0;
                        rrPtr      <= selIdx + 2'd1;
                        owner      <= selIdx;
                    end
                end
                COUNT: begin
                    // A completing edge wins over a simultaneous request drop.
                    if (lastEdge) begin
                        state      <= HOLDOFF;
                        bus.grant  <= '0;
                        bus.window <= 1'b0;
                        bus.done   <= bus.grant;
                        edgeCnt    <= edgeCnt + 5'd1;
                        holdCnt    <= 4'(HOLDOFF_CYCLES - 1);
                    end else if (!bus.req[owner]) begin
                        state      <= HOLDOFF;
                        bus.grant  <= '0;
                        bus.window <= 1'b0;
                        bus.abort  <= 1'b1;
                        holdCnt    <= 4'(HOLDOFF_CYCLES - 1);
                    end else if (fallEvent) begin
                        edgeCnt    <= edgeCnt + 5'd1;
                    end
                end
                HOLDOFF: begin
                    if (holdCnt == 4'd0) begin
                        state <= IDLE;
                    end else begin
                        holdCnt <= holdCnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_feedback_burst_scheduler.sv
// Directed bench for feedback_burst_scheduler at default parameters (holdoff 2, two sync stages).
// Fall detection takes three sysclk edges from the ext_clk transition to the FSM reacting.
module tb_feedback_burst_scheduler;

    logic sysclk  = 1'b0;
    logic reset   = 1'b0;
    logic ext_clk = 1'b1;
    int   checkCount = 0;
    int   passCount  = 0;

    feedback_burst_scheduler_if bus ();

    feedback_burst_scheduler dut (
        .sysclk  (sysclk),
        .reset   (reset),
        .ext_clk (ext_clk),
        .bus     (bus)
    );

    always #5 sysclk = ~sysclk;

    task automatic step();
        @(posedge sysclk);
        #1;
    endtask

    // On return, the FSM has just acted on the fall event, so done is visible now.
    task automatic fallLow();
        ext_clk = 1'b0;
        repeat (3) step();
    endtask

    task automatic riseHigh();
        ext_clk = 1'b1;
        repeat (3) step();
    endtask

    task automatic test_reset();
        bus.req     = 4'b0000;
        bus.len_bus = 16'h0000;
        reset       = 1'b0;
        repeat (2) step();
        checkCount++; if (bus.grant !== 4'b0000) $display("[TB] FAIL reset_grant: got %b expected 0000", bus.grant); else passCount++;
        checkCount++; if (bus.window !== 1'b0) $display("[TB] FAIL reset_window: got %b expected 0", bus.window); else passCount++;
        checkCount++; if (bus.done !== 4'b0000) $display("[TB] FAIL reset_done: got %b expected 0000", bus.done); else passCount++;
        checkCount++; if (bus.abort !== 1'b0) $display("[TB] FAIL reset_abort: got %b expected 0", bus.abort); else passCount++;
        checkCount++; if (bus.busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); else passCount++;
        reset = 1'b1;
        step();
    endtask

    task automatic test_single_burst();
        bus.req     = 4'b0001;
        bus.len_bus = 16'h0003;
        step();
        checkCount++; if (bus.grant !== 4'b0001) $display("[TB] FAIL single_grant: got %b expected 0001", bus.grant); else passCount++;
        checkCount++; if (bus.window !== 1'b1) $display("[TB] FAIL single_window: got %b expected 1", bus.window); else passCount++;
        checkCount++; if (bus.busy !== 1'b1) $display("[TB] FAIL single_busy: got %b expected 1", bus.busy); else passCount++;
        fallLow(); riseHigh();
        fallLow(); riseHigh();
        checkCount++; if (bus.window !== 1'b1 || bus.done !== 4'b0000) $display("[TB] FAIL single_after2: got window %b done %b expected 1 0000", bus.window, bus.done); else passCount++;
        fallLow();
        checkCount++; if (bus.done !== 4'b0001) $display("[TB] FAIL single_done: got %b expected 0001", bus.done); else passCount++;
        checkCount++; if (bus.grant !== 4'b0000 || bus.window !== 1'b0) $display("[TB] FAIL single_release: got grant %b window %b expected 0000 0", bus.grant, bus.window); else passCount++;
        bus.req = 4'b0000;
        step();
        checkCount++; if (bus.done !== 4'b0000 || bus.busy !== 1'b1) $display("[TB] FAIL single_holdoff: got done %b busy %b expected 0000 1", bus.done, bus.busy); else passCount++;
        step();
        checkCount++; if (bus.busy !== 1'b0) $display("[TB] FAIL single_idle: got busy %b expected 0", bus.busy); else passCount++;
        riseHigh();
    endtask

    task automatic test_round_robin();
        logic [3:0] expGrant;
        logic [3:0] nextGrant;
        reset = 1'b0;
        step();
        reset       = 1'b1;
        bus.req     = 4'b1111;
        bus.len_bus = 16'h1111;
        step();
        checkCount++; if (bus.grant !== 4'b0001) $display("[TB] FAIL rr_first: got %b expected 0001", bus.grant); else passCount++;
        for (int k = 0; k < 4; k++) begin
            expGrant  = 4'(1 << k);
            nextGrant = 4'(1 << ((k + 1) % 4));
            fallLow();
            checkCount++; if (bus.done !== expGrant || bus.grant !== 4'b0000) $display("[TB] FAIL rr_done%0d: got done %b grant %b expected %b 0000", k, bus.done, bus.grant, expGrant); else passCount++;
            step();
            checkCount++; if (bus.done !== 4'b0000) $display("[TB] FAIL rr_pulse%0d: got %b expected 0000", k, bus.done); else passCount++;
            step();
            checkCount++; if (bus.grant !== 4'b0000) $display("[TB] FAIL rr_gap%0d: got %b expected 0000", k, bus.grant); else passCount++;
            step();
            checkCount++; if (bus.grant !== nextGrant) $display("[TB] FAIL rr_next%0d: got %b expected %b", k, bus.grant, nextGrant); else passCount++;
            riseHigh();
        end
        bus.req = 4'b0000;
        step();
        checkCount++; if (bus.abort !== 1'b1 || bus.done !== 4'b0000) $display("[TB] FAIL rr_drop: got abort %b done %b expected 1 0000", bus.abort, bus.done); else passCount++;
        repeat (2) step();
    endtask

    task automatic test_len16();
        logic sawDone;
        sawDone     = 1'b0;
        bus.req     = 4'b0100;
        bus.len_bus = 16'hF0FF;
        step();
        checkCount++; if (bus.grant !== 4'b0100) $display("[TB] FAIL len16_grant: got %b expected 0100", bus.grant); else passCount++;
        bus.len_bus = 16'h0300;
        for (int n = 0; n < 15; n++) begin
            fallLow();
            if (bus.done !== 4'b0000) sawDone = 1'b1;
            riseHigh();
        end
        checkCount++; if (sawDone !== 1'b0 || bus.window !== 1'b1) $display("[TB] FAIL len16_early: got sawDone %b window %b expected 0 1", sawDone, bus.window); else passCount++;
        fallLow();
        checkCount++; if (bus.done !== 4'b0100 || bus.grant !== 4'b0000) $display("[TB] FAIL len16_done: got done %b grant %b expected 0100 0000", bus.done, bus.grant); else passCount++;
        bus.req = 4'b0000;
        riseHigh();
        fallLow();
        checkCount++; if (bus.done !== 4'b0000 || bus.abort !== 1'b0 || bus.grant !== 4'b0000 || bus.busy !== 1'b0) $display("[TB] FAIL len16_extra: got done %b abort %b grant %b busy %b expected 0000 0 0000 0", bus.done, bus.abort, bus.grant, bus.busy); else passCount++;
        riseHigh();
    endtask

    task automatic test_abort();
        bus.req     = 4'b0010;
        bus.len_bus = 16'h0080;
        step();
        checkCount++; if (bus.grant !== 4'b0010) $display("[TB] FAIL abort_grant: got %b expected 0010", bus.grant); else passCount++;
        repeat (4) begin
            fallLow();
            riseHigh();
        end
        bus.req = 4'b0000;
        step();
        checkCount++; if (bus.abort !== 1'b1 || bus.done !== 4'b0000) $display("[TB] FAIL abort_pulse: got abort %b done %b expected 1 0000", bus.abort, bus.done); else passCount++;
        checkCount++; if (bus.grant !== 4'b0000 || bus.window !== 1'b0) $display("[TB] FAIL abort_release: got grant %b window %b expected 0000 0", bus.grant, bus.window); else passCount++;
        step();
        checkCount++; if (bus.abort !== 1'b0) $display("[TB] FAIL abort_oneshot: got %b expected 0", bus.abort); else passCount++;
        step();
        checkCount++; if (bus.busy !== 1'b0) $display("[TB] FAIL abort_idle: got busy %b expected 0", bus.busy); else passCount++;
    endtask

    task automatic test_back_to_back_drop();
        bus.req     = 4'b0001;
        bus.len_bus = 16'h0002;
        step();
        checkCount++; if (bus.grant !== 4'b0001) $display("[TB] FAIL same_grant: got %b expected 0001", bus.grant); else passCount++;
        fallLow();
        riseHigh();
        ext_clk = 1'b0;
        repeat (2) step();
        bus.req = 4'b0000;
        step();
        checkCount++; if (bus.done !== 4'b0001 || bus.abort !== 1'b0) $display("[TB] FAIL same_done: got done %b abort %b expected 0001 0", bus.done, bus.abort); else passCount++;
        step();
        checkCount++; if (bus.done !== 4'b0000 || bus.abort !== 1'b0) $display("[TB] FAIL same_after: got done %b abort %b expected 0000 0", bus.done, bus.abort); else passCount++;
        riseHigh();
    endtask

    task automatic test_reset_mid_count();
        bus.req     = 4'b0100;
        bus.len_bus = 16'h0800;
        step();
        checkCount++; if (bus.grant !== 4'b0100) $display("[TB] FAIL midrst_grant: got %b expected 0100", bus.grant); else passCount++;
        repeat (5) begin
            fallLow();
            riseHigh();
        end
        reset = 1'b0;
        step();
        checkCount++; if (bus.grant !== 4'b0000 || bus.window !== 1'b0 || bus.done !== 4'b0000 || bus.abort !== 1'b0 || bus.busy !== 1'b0) $display("[TB] FAIL midrst_clear: got grant %b window %b done %b abort %b busy %b expected all 0", bus.grant, bus.window, bus.done, bus.abort, bus.busy); else passCount++;
        reset       = 1'b1;
        bus.req     = 4'b1000;
        bus.len_bus = 16'h1000;
        step();
        checkCount++; if (bus.grant !== 4'b1000 || bus.window !== 1'b1) $display("[TB] FAIL midrst_regrant: got grant %b window %b expected 1000 1", bus.grant, bus.window); else passCount++;
        fallLow();
        checkCount++; if (bus.done !== 4'b1000) $display("[TB] FAIL midrst_fresh: got %b expected 1000", bus.done); else passCount++;
        bus.req = 4'b0000;
        riseHigh();
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_round_robin();
        test_len16();
        test_abort();
        test_back_to_back_drop();
        test_reset_mid_count();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/feedback_burst_scheduler.md
FEEDBACK_BURST_SCHEDULER -- requirements
Module: feedback_burst_scheduler

Interface
REQ-001 Parameter HOLDOFF_CYCLES, default 2, sysclk cycles of idle gap between bursts (legal 1..15).
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer depth on ext_clk (legal 2..3).
REQ-003 sysclk  input  1  system clock; all state changes on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-low.
REQ-005 ext_clk  input  1  asynchronous feedback edge source; falling edges are counted.
REQ-006 req  input  4  per-requester burst request, level, held until done or abort.
REQ-007 len_bus  input  16  burst lengths, requester i uses bits [4i+3:4i]; value 0 means 16 edges.
REQ-008 grant  output  4  one-hot owner of the counting window; all-zero when no owner.
REQ-009 window  output  1  high while the granted burst is counting edges.
REQ-010 done  output  4  one-cycle pulse on bit i when requester i's burst completes.
REQ-011 abort  output  1  one-cycle pulse when a burst ends early because its req dropped.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 ext_clk SHALL pass through SYNC_STAGES flops plus one history flop; fall event = history high and synchronized value low, at most one event per sysclk.
REQ-014 The FSM SHALL have states IDLE, COUNT, HOLDOFF; busy = (state != IDLE).
REQ-015 IDLE: when req != 0, select the first asserted bit searching upward from rr_ptr with wrap (3 -> 0); next cycle state = COUNT, grant = that one-hot bit, window = 1.
REQ-016 At grant, target SHALL be latched from the selected len_bus field (0 -> 16), edge_cnt (5 bits) cleared, rr_ptr set to (selected index + 1) mod 4.
REQ-017 len_bus changes after grant SHALL NOT affect the running burst.
REQ-018 COUNT: each fall event SHALL increment edge_cnt by 1; no wrap is possible (max 16).
REQ-019 COUNT: a fall event with edge_cnt == target-1 SHALL complete the burst: next cycle state = HOLDOFF, grant = 0, window = 0, done[owner] = 1 for exactly that one cycle.
REQ-020 COUNT: req[owner] == 0 (with no completing event that cycle) SHALL abort: next cycle state = HOLDOFF, grant = 0, window = 0, abort = 1 for one cycle, done stays 0.
REQ-021 Completion and req drop in the same cycle SHALL be treated as completion (done, no abort).
REQ-022 Requests from non-owners during COUNT or HOLDOFF SHALL be ignored until IDLE; no preemption.
REQ-023 HOLDOFF SHALL last exactly HOLDOFF_CYCLES cycles, then IDLE; earliest next grant is the cycle after IDLE is entered if req != 0 (i.e. grant visible HOLDOFF_CYCLES+1 cycles after done).
REQ-024 Fall events outside COUNT SHALL be discarded; they are never counted toward a later burst.
REQ-025 grant SHALL never have more than one bit set; window SHALL equal (grant != 0).

Reset
REQ-026 reset low at a sysclk edge SHALL force: state IDLE, grant 0, window 0, done 0, abort 0, busy 0, rr_ptr 0, edge_cnt 0, synchronizer and history flops 1.
REQ-027 Reset mid-COUNT SHALL end the burst with no done and no abort pulse.
REQ-028 After reset release, the first grant SHALL follow REQ-015 with rr_ptr = 0.

Verification
REQ-029 req=0001, len field0=3, 3 ext_clk falls -> grant=0001, window=1 until 3rd fall detected; done=0001 one cycle; busy low 2 cycles later.
REQ-030 req=1111 held, all lengths 1 -> grant order 0001, 0010, 0100, 1000, 0001; each done one cycle; 3-cycle gap from done to next grant.
REQ-031 req=0100, len field2=0 -> exactly 16 falls counted before done=0100; a 17th fall during HOLDOFF has no effect.
REQ-032 req=0010 granted, len=8, drop req after 4 falls -> abort=1 one cycle, done=0000, grant=0 next cycle.
REQ-033 Drop req on the same cycle the final fall is detected -> done pulses, abort stays 0.
REQ-034 Assert reset during COUNT with 5 of 8 edges counted -> all outputs 0 next cycle; after release req=1000 alone -> grant=1000 with fresh count of 0.
